tone_player: RTL

TONE_PLAYER -- requirements
Module: tone_player

---
 rtl/tone_player.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/tone_player.sv
// Tone player: plays one latched note as a square wave for a set number of
// cycles, then holds a silent gap before reporting completion.
module tone_player #(
    parameter int unsigned NUM_NOTES  = 5,
    parameter int unsigned DIV_W      = 24,
    parameter int unsigned DUR_W      = 28,
    parameter logic [NUM_NOTES*DIV_W-1:0] NOTE_HALF = {
        DIV_W'(113636), DIV_W'(125000), DIV_W'(142857),
        DIV_W'(166667), DIV_W'(200000)
    },
    parameter int unsigned GAP_CYCLES = 5_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_NOTES-1:0] note_sel,
    input  logic [DUR_W-1:0]     duration,
    input  logic                 start,
    input  logic                 stop,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [NUM_NOTES-1:0] active_note,
    output logic                 speaker
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]           state,       state_nxt;
    logic [DIV_W-1:0]     half_lim,    half_lim_nxt;
    logic [DIV_W-1:0]     half_cnt,    half_cnt_nxt;
    logic [DUR_W-1:0]     dur_cnt,     dur_cnt_nxt;
    logic [GAP_W-1:0]     gap_cnt,     gap_cnt_nxt;
    logic                 speaker_nxt;
    logic                 busy_nxt;
    logic                 done_nxt;
    logic                 err_nxt;
    logic [NUM_NOTES-1:0] active_note_nxt;

    logic [DIV_W-1:0]     sel_half;
    logic [DIV_W-1:0]     sel_half_lim;
    logic                 sel_onehot;
    logic                 start_ok;

    // Look up the half-period of the requested note; a zero entry behaves as 1
    always_comb begin
        sel_half = '0;
        for (int i = 0; i < int'(NUM_NOTES); i++) begin
            if (note_sel[i]) begin
                sel_half = sel_half | NOTE_HALF[i*DIV_W +: DIV_W];
            end
        end
        sel_half_lim = (sel_half == '0) ? '0 : sel_half - DIV_W'(1);
        sel_onehot   = (note_sel != '0) &&
                       ((note_sel & (note_sel - NUM_NOTES'(1))) == '0);
        start_ok     = sel_onehot && (duration != '0);
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt       = state;
        half_lim_nxt    = half_lim;
        half_cnt_nxt    = half_cnt;
        dur_cnt_nxt     = dur_cnt;
        gap_cnt_nxt     = gap_cnt;
        speaker_nxt     = speaker;
        busy_nxt        = busy;
        done_nxt        = 1'b0;
        err_nxt         = 1'b0;
        active_note_nxt = active_note;

        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    if (start_ok) begin
                        state_nxt       = S_PLAY;
                        half_lim_nxt    = sel_half_lim;
                        half_cnt_nxt    = '0;
                        dur_cnt_nxt     = duration;
                        speaker_nxt     = 1'b0;
                        busy_nxt        = 1'b1;
                        active_note_nxt = note_sel;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            S_PLAY: begin
                if (stop) begin
                    state_nxt       = S_IDLE;
                    half_cnt_nxt    = '0;
                    dur_cnt_nxt     = '0;
                    gap_cnt_nxt     = '0;
                    speaker_nxt     = 1'b0;
                    busy_nxt        = 1'b0;
                    active_note_nxt = '0;
                end else if (dur_cnt <= DUR_W'(1)) begin
                    half_cnt_nxt = '0;
                    dur_cnt_nxt  = '0;
                    speaker_nxt  = 1'b0;
                    if (GAP_CYCLES == 0) begin
                        state_nxt       = S_IDLE;
                        busy_nxt        = 1'b0;
                        done_nxt        = 1'b1;
                        active_note_nxt = '0;
                    end else begin
                        state_nxt   = S_GAP;
                        gap_cnt_nxt = GAP_W'(GAP_CYCLES);
                    end
                end else begin
                    dur_cnt_nxt = dur_cnt - DUR_W'(1);
                    if (half_cnt >= half_lim) begin
                        half_cnt_nxt = '0;
                        speaker_nxt  = ~speaker;
                    end else begin
                        half_cnt_nxt = half_cnt + DIV_W'(1);
                    end
                end
            end

            S_GAP: begin
                if (stop) begin
                    state_nxt       = S_IDLE;
                    gap_cnt_nxt     = '0;
                    speaker_nxt     = 1'b0;
                    busy_nxt        = 1'b0;
                    active_note_nxt = '0;
                end else if (gap_cnt <= GAP_W'(1)) begin
                    state_nxt       = S_IDLE;
                    gap_cnt_nxt     = '0;
                    busy_nxt        = 1'b0;
                    done_nxt        = 1'b1;
                    active_note_nxt = '0;
                end else begin
                    gap_cnt_nxt = gap_cnt - GAP_W'(1);
                end
            end

            default: begin
                state_nxt       = S_IDLE;
                half_cnt_nxt    = '0;
                dur_cnt_nxt     = '0;
                gap_cnt_nxt     = '0;
                speaker_nxt     = 1'b0;
                busy_nxt        = 1'b0;
                active_note_nxt = '0;
            end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            half_lim    <= '0;
            half_cnt    <= '0;
            dur_cnt     <= '0;
            gap_cnt     <= '0;
            speaker     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            active_note <= '0;
        end else begin
            state       <= state_nxt;
            half_lim    <= half_lim_nxt;
            half_cnt    <= half_cnt_nxt;
            dur_cnt     <= dur_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            speaker     <= speaker_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            err         <= err_nxt;
            active_note <= active_note_nxt;
        end
    end

endmodule
